// File: rtl/aclk_pkg.sv
// Shared types and constants for the alarm-clock control state machine.
// The state encoding is fixed because it is exported on the optional debug port.
package aclk_pkg;

  localparam int KEY_W = 4;
  localparam logic [KEY_W-1:0] NOKEY_CODE = 4'd10;
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_STORED       = 3'd1,
    KEY_WAITED       = 3'd2,
    KEY_ENTRY        = 3'd3,
    SHOW_ALARM       = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_e;

  // Codes at or above the idle code (including 11-15) count as "no key".
  function automatic logic key_is_digit(input logic [KEY_W-1:0] key_code,
                                        input logic [KEY_W-1:0] nokey_code);
    return key_code < nokey_code;
  endfunction

endpackage

// File: rtl/aclk_timeout_cnt.sv
// Inactivity timer: counts one_second rising edges while enabled and
// saturates at TIMEOUT_SEC; clear has priority over counting.
module aclk_timeout_cnt
  import aclk_pkg::*;
#(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic one_second,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_SEC);

  logic             one_sec_q;
  logic             one_sec_rise;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign one_sec_rise = one_second & ~one_sec_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && one_sec_rise && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      one_sec_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      one_sec_q <= one_second;
      cnt_q     <= cnt_d;
    end
  end

  assign timeout = (cnt_q == LIMIT);

endmodule

// File: rtl/aclk_ctrl_fsm.sv
// Alarm-clock main control FSM (Moore): keypad entry, alarm/time load, display select.
// Optional macro ACLK_CTRL_DBG_EN exposes the encoded current state on dbg_state.
module aclk_ctrl_fsm
  import aclk_pkg::*;
#(
  parameter int               TIMEOUT_SEC = 10,
  parameter logic [KEY_W-1:0] NOKEY       = NOKEY_CODE
) (
`ifdef ACLK_CTRL_DBG_EN
  output logic [2:0]       dbg_state,
`endif
  input  logic             clk,
  input  logic             reset,
  input  logic             one_second,
  input  logic             alarm_button,
  input  logic             time_button,
  input  logic [KEY_W-1:0] key,
  output logic             reset_count,
  output logic             load_new_c,
  output logic             show_new_time,
  output logic             show_a,
  output logic             load_new_a,
  output logic             shift
);

  state_e state_q;
  state_e state_d;
  logic   key_present;
  logic   in_window;
  logic   timeout;

  assign key_present = key_is_digit(key, NOKEY);

  // Only the two "waiting for the user" states run the inactivity window;
  // KEY_STORED sits outside it, so every new digit restarts the count.
  assign in_window = (state_q == KEY_WAITED) || (state_q == KEY_ENTRY);

  aclk_timeout_cnt #(
    .TIMEOUT_SEC (TIMEOUT_SEC)
  ) u_timeout_cnt (
    .clk        (clk),
    .reset      (reset),
    .one_second (one_second),
    .clr        (~in_window),
    .en         (in_window),
    .timeout    (timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SHOW_TIME;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    reset_count   = 1'b0;
    load_new_c    = 1'b0;
    show_new_time = 1'b0;
    show_a        = 1'b0;
    load_new_a    = 1'b0;
    shift         = 1'b0;

    unique case (state_q)
      SHOW_TIME: begin
        if (alarm_button) begin
          state_d = SHOW_ALARM;
        end else if (key_present) begin
          state_d = KEY_STORED;
        end
      end

      KEY_STORED: begin
        shift         = 1'b1;
        show_new_time = 1'b1;
        state_d       = KEY_WAITED;
      end

      // Waiting for release keeps a held key from being shifted twice.
      KEY_WAITED: begin
        show_new_time = 1'b1;
        if (!key_present) begin
          state_d = KEY_ENTRY;
        end else if (timeout) begin
          state_d = SHOW_TIME;
        end
      end

      KEY_ENTRY: begin
        show_new_time = 1'b1;
        if (alarm_button) begin
          state_d = SET_ALARM_TIME;
        end else if (time_button) begin
          state_d = SET_CURRENT_TIME;
        end else if (key_present) begin
          state_d = KEY_STORED;
        end else if (timeout) begin
          state_d = SHOW_TIME;
        end
      end

      SHOW_ALARM: begin
        show_a = 1'b1;
        if (!alarm_button) begin
          state_d = SHOW_TIME;
        end
      end

      SET_ALARM_TIME: begin
        load_new_a = 1'b1;
        state_d    = SHOW_TIME;
      end

      SET_CURRENT_TIME: begin
        load_new_c  = 1'b1;
        reset_count = 1'b1;
        state_d     = SHOW_TIME;
      end

      default: begin
        state_d = SHOW_TIME;
      end
    endcase
  end

`ifdef ACLK_CTRL_DBG_EN
  assign dbg_state = state_q;
`endif

endmodule

// File: tb/tb_aclk_ctrl_fsm.sv
// Self-checking bench for aclk_ctrl_fsm: directed test-plan steps followed by
// random traffic, every cycle compared against a behavioural mode model.
module tb_aclk_ctrl_fsm;

  localparam int         TIMEOUT = 10;
  localparam logic [3:0] NK      = 4'd10;

  localparam int M_SHOW  = 0;
  localparam int M_STORE = 1;
  localparam int M_WAIT  = 2;
  localparam int M_ENTRY = 3;
  localparam int M_ALARM = 4;
  localparam int M_SETA  = 5;
  localparam int M_SETC  = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       one_second = 1'b0;
  logic       alarm_button = 1'b0;
  logic       time_button = 1'b0;
  logic [3:0] key = NK;
  logic       reset_count, load_new_c, show_new_time, show_a, load_new_a, shift;
  logic [5:0] outs;
`ifdef ACLK_CTRL_DBG_EN
  logic [2:0] dbg_state;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tick_ph = 0;
  int shift_n = 0, loada_n = 0, loadc_n = 0, rc_n = 0;

  int m_mode = M_SHOW;
  int m_idle = 0;
  bit m_prev = 1'b0;

  always #5 clk = ~clk;

  aclk_ctrl_fsm #(
    .TIMEOUT_SEC (TIMEOUT),
    .NOKEY       (NK)
  ) dut (
`ifdef ACLK_CTRL_DBG_EN
    .dbg_state     (dbg_state),
`endif
    .clk           (clk),
    .reset         (reset),
    .one_second    (one_second),
    .alarm_button  (alarm_button),
    .time_button   (time_button),
    .key           (key),
    .reset_count   (reset_count),
    .load_new_c    (load_new_c),
    .show_new_time (show_new_time),
    .show_a        (show_a),
    .load_new_a    (load_new_a),
    .shift         (shift)
  );

  assign outs = {reset_count, load_new_c, show_new_time, show_a, load_new_a, shift};

  // What the user should see in each mode: {reset_count, load_c, show_new, show_a, load_a, shift}.
  function automatic logic [5:0] exp_outs(int mode);
    case (mode)
      M_STORE: return 6'b001001;
      M_WAIT:  return 6'b001000;
      M_ENTRY: return 6'b001000;
      M_ALARM: return 6'b000100;
      M_SETA:  return 6'b000010;
      M_SETC:  return 6'b110000;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic check(string tag, logic [5:0] obs, logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_int(string tag, int obs, int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_SHOW;
    m_idle = 0;
    m_prev = 1'b0;
  endtask

  // One clock of the user-level rules: idle seconds accumulate only while
  // the machine waits on the user, then the mode moves on.
  task automatic model_step(bit a, bit t, logic [3:0] k, bit os);
    bit digit;
    bit rise;
    bit expired;
    int nxt;
    digit   = (k <= 4'd9);
    rise    = os && !m_prev;
    expired = (m_idle == TIMEOUT);
    nxt     = m_mode;
    if (m_mode == M_WAIT || m_mode == M_ENTRY) begin
      if (rise && m_idle < TIMEOUT) m_idle = m_idle + 1;
    end else begin
      m_idle = 0;
    end
    case (m_mode)
      M_SHOW:  nxt = a ? M_ALARM : (digit ? M_STORE : M_SHOW);
      M_STORE: nxt = M_WAIT;
      M_WAIT:  nxt = !digit ? M_ENTRY : (expired ? M_SHOW : M_WAIT);
      M_ENTRY: nxt = a ? M_SETA : t ? M_SETC : digit ? M_STORE : expired ? M_SHOW : M_ENTRY;
      M_ALARM: nxt = a ? M_ALARM : M_SHOW;
      default: nxt = M_SHOW;
    endcase
    m_mode = nxt;
    m_prev = os;
  endtask

  task automatic step(bit a, bit t, logic [3:0] k, bit os, bit r, string tag);
    alarm_button = a;
    time_button  = t;
    key          = k;
    one_second   = os;
    reset        = r;
    if (!r) begin
      #1;
      model_reset();
      check({tag, "_async_rst"}, outs, 6'b000000);
    end
    @(posedge clk);
    cyc++;
    if (r) model_step(a, t, k, os);
    else   model_reset();
    #1;
    check(tag, outs, exp_outs(m_mode));
`ifdef ACLK_CTRL_DBG_EN
    check_int({tag, "_dbg"}, int'(dbg_state), m_mode);
`endif
    shift_n += int'(shift);
    loada_n += int'(load_new_a);
    loadc_n += int'(load_new_c);
    rc_n    += int'(reset_count);
  endtask

  // Directed traffic with a one_second pulse every fourth cycle.
  task automatic run(bit a, bit t, logic [3:0] k, int n, string tag);
    for (int i = 0; i < n; i++) begin
      step(a, t, k, (tick_ph % 4) == 0, 1'b1, tag);
      tick_ph++;
    end
  endtask

  task automatic enter_digit(logic [3:0] d);
    run(1'b0, 1'b0, d, 1, "digit_press");
    check_int("digit_shift_pulse", int'(shift), 1);
    run(1'b0, 1'b0, NK, 2, "digit_release");
    check_int("shift_once", int'(shift), 0);
    check_int("show_new_time_held", int'(show_new_time), 1);
  endtask

  initial begin
    int digs_a[4] = '{2, 5, 3, 9};
    int digs_c[3] = '{1, 2, 6};
    int waited;
    bit dropped;

    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("reset_outputs", outs, 6'b000000);
    step(1'b0, 1'b0, NK, 1'b0, 1'b0, "reset_hold");
    step(1'b1, 1'b0, 4'd3, 1'b1, 1'b0, "reset_hold_busy_inputs");
    run(1'b0, 1'b0, NK, 3, "idle");
    check("idle_outputs", outs, 6'b000000);

    shift_n = 0;
    foreach (digs_a[i]) enter_digit(4'(digs_a[i]));
    check_int("four_shift_pulses", shift_n, 4);

    loada_n = 0;
    run(1'b1, 1'b0, NK, 1, "alarm_load");
    check_int("load_new_a_pulse", int'(load_new_a), 1);
    run(1'b1, 1'b0, NK, 1, "after_alarm_load");
    check("show_time_after_load", outs, 6'b000000);
    run(1'b1, 1'b0, NK, 3, "alarm_held");
    check_int("show_a_while_held", int'(show_a), 1);
    run(1'b0, 1'b0, NK, 2, "alarm_release");
    check_int("show_a_released", int'(show_a), 0);
    check_int("single_load_a", loada_n, 1);

    loadc_n = 0;
    rc_n = 0;
    foreach (digs_c[i]) enter_digit(4'(digs_c[i]));
    run(1'b0, 1'b1, NK, 1, "time_load");
    check("time_load_strobes", outs, 6'b110000);
    run(1'b0, 1'b1, NK, 3, "time_held_ignored");
    check("time_button_ignored", outs, 6'b000000);
    check_int("single_load_c", loadc_n, 1);
    check_int("single_reset_count", rc_n, 1);

    loada_n = 0;
    loadc_n = 0;
    run(1'b0, 1'b0, 4'd4, 1, "timeout_key");
    run(1'b0, 1'b0, NK, 1, "timeout_release");
    waited = 0;
    dropped = 1'b0;
    for (int i = 0; i < 80 && !dropped; i++) begin
      run(1'b0, 1'b0, NK, 1, "timeout_wait");
      waited++;
      dropped = !show_new_time;
    end
    check_int("timeout_returns", int'(dropped), 1);
    check_int("timeout_not_early", int'(waited >= 4 * (TIMEOUT - 1)), 1);
    check_int("timeout_no_load", loada_n + loadc_n, 0);

    shift_n = 0;
    run(1'b0, 1'b0, 4'd7, 1, "held7_press");
    dropped = 1'b0;
    for (int i = 0; i < 80 && !dropped; i++) begin
      run(1'b0, 1'b0, 4'd7, 1, "held7_wait");
      dropped = !show_new_time;
    end
    check_int("held_key_timeout", int'(dropped), 1);
    check_int("held_key_one_shift", shift_n, 1);
    run(1'b0, 1'b0, NK, 2, "held7_release");

    shift_n = 0;
    loada_n = 0;
    loadc_n = 0;
    run(1'b0, 1'b0, 4'd5, 20, "hold5");
    check_int("hold5_one_shift", shift_n, 1);
    run(1'b0, 1'b0, NK, 2, "hold5_release");
    run(1'b1, 1'b1, NK, 1, "both_buttons");
    check_int("both_alarm_wins", int'(load_new_a), 1);
    check_int("both_no_load_c", int'(load_new_c), 0);
    run(1'b0, 1'b0, NK, 2, "both_release");

    loada_n = 0;
    loadc_n = 0;
    run(1'b0, 1'b0, 4'd8, 1, "mid_key");
    run(1'b0, 1'b0, NK, 2, "mid_release");
    step(1'b0, 1'b1, NK, 1'b0, 1'b0, "mid_reset");
    step(1'b0, 1'b1, NK, 1'b0, 1'b0, "mid_reset_hold");
    run(1'b0, 1'b0, NK, 3, "mid_after");
    check_int("mid_reset_no_load", loada_n + loadc_n, 0);

    for (int i = 0; i < 1500; i++) begin
      bit a, t, os, r;
      logic [3:0] k;
      a  = ($urandom_range(0, 9) == 0);
      t  = ($urandom_range(0, 9) == 0);
      os = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 199) != 0);
      k  = ($urandom_range(0, 9) < 4) ? 4'($urandom_range(0, 15)) : NK;
      step(a, t, k, os, r, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
